mod_n_counter: RTL and testbench

- Parametrised synchronous modulo-N counter built from T flip-flop cells.
- Generalises the fixed mod-5 counter with:
  - configurable modulus and width
  - enable, synchronous clear and parallel load
  - terminal-count and cascade carry outputs
  - optional down-counting (compile-time)
- Sits in the ADLD counter library as the general building block for dividers, sequencers and cascaded multi-digit counters.

---
 rtl/mod_counter_pkg.sv | 22 ++
 rtl/mod_n_counter_t_flip_flop.sv | 17 +
 rtl/mod_n_counter.sv | 96 +++++++++
 tb/tb_mod_n_counter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mod_counter_pkg.sv
// Shared definitions for the modulo-N counter library: direction encoding,
// next-state action codes and the terminal-value helper.
package mod_counter_pkg;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

   // Decoded per-edge action, highest-priority source wins.
   typedef enum logic [2:0] {
      ACT_HOLD   = 3'd0,
      ACT_CLEAR  = 3'd1,
      ACT_LOAD   = 3'd2,
      ACT_REJECT = 3'd3,
      ACT_COUNT  = 3'd4
   } act_e;

   function automatic int unsigned terminal_value(input int unsigned modulus,
                                                  input logic        dir);
      return (dir == DIR_DOWN) ? 0 : modulus - 1;
   endfunction

endpackage : mod_counter_pkg

// File: rtl/mod_n_counter_t_flip_flop.sv
// Single-bit toggle cell: Q inverts on a rising Clock edge while T is high.
// Asynchronous active-high Reset clears Q.
module t_flip_flop (
   input  logic Clock,
   input  logic Reset,
   input  logic T,
   output logic Q
);

   // NOTE: state is updated with non-blocking assignments so every cell samples
   // the pre-edge Count and the whole word switches together.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset)  Q <= 1'b0;
      else if (T) Q <= ~Q;
   end

endmodule : t_flip_flop

// File: rtl/mod_n_counter.sv
// Parametrised synchronous modulo-N counter built from T cells, with clear,
// load, enable, terminal count and cascade carry. Down-counting is compiled in
// only when MODN_COUNTER_DOWN_EN is defined.
module mod_n_counter
   import mod_counter_pkg::*;
#(
   parameter int MODULUS = 5,
   parameter int WIDTH   = 3
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Enable,
   input  logic             Clear,
   input  logic             Load,
   input  logic [WIDTH-1:0] LoadValue,
   input  logic             Dir,
   output logic [WIDTH-1:0] Count,
   output logic             TerminalCount,
   output logic             CarryOut,
   output logic             LoadErr
);

   localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

   if (MODULUS < 2 || (2 ** WIDTH) < MODULUS) begin : g_bad_params
      $error("mod_n_counter: need MODULUS >= 2 and 2**WIDTH >= MODULUS");
   end

   act_e             act;
   logic             load_ok;
   logic             count_legal;
   logic [WIDTH-1:0] count_next;
   logic [WIDTH-1:0] toggle;

   // One extra bit so the comparison still works when 2**WIDTH == MODULUS.
   assign load_ok     = ({1'b0, LoadValue} < MOD_EXT);
   assign count_legal = ({1'b0, Count}     < MOD_EXT);

   always_comb begin
      act = ACT_HOLD;
      if (Clear)       act = ACT_CLEAR;
      else if (Load)   act = load_ok ? ACT_LOAD : ACT_REJECT;
      else if (Enable) act = ACT_COUNT;
   end

   // NOTE: count_next gets its hold value first so no path through the case
   // leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      count_next = Count;
      unique case (act)
         ACT_CLEAR: count_next = '0;
         ACT_LOAD:  count_next = LoadValue;
         ACT_COUNT: begin
            if (!count_legal) begin
               count_next = '0;
`ifdef MODN_COUNTER_DOWN_EN
            end else if (Dir == DIR_DOWN) begin
               count_next = (Count == '0) ? LAST : Count - WIDTH'(1);
`endif
            end else begin
               count_next = (Count == LAST) ? '0 : Count + WIDTH'(1);
            end
         end
         default: ;
      endcase
   end

   assign toggle = count_next ^ Count;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      t_flip_flop u_cell (
         .Clock (Clock),
         .Reset (Reset),
         .T     (toggle[i]),
         .Q     (Count[i])
      );
   end

`ifdef MODN_COUNTER_DOWN_EN
   assign TerminalCount = (Count == WIDTH'(terminal_value(MODULUS, Dir)));
`else
   logic unused_dir;
   assign unused_dir    = Dir;
   assign TerminalCount = (Count == LAST);
`endif

   assign CarryOut = Enable & TerminalCount;

   // A rejected load only exists when Clear is low, so Clear suppresses LoadErr.
   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) LoadErr <= 1'b0;
      else       LoadErr <= (act == ACT_REJECT);
   end

endmodule : mod_n_counter

// File: tb/tb_mod_n_counter.sv
// Self-checking bench for mod_n_counter: directed scenarios, a randomized run
// against an arithmetic reference model, and a two-digit decade cascade.
module tb_mod_n_counter;

   localparam int MOD = 5;
   localparam int W   = 3;
`ifdef MODN_COUNTER_DOWN_EN
   localparam bit DOWN_EN = 1'b1;
`else
   localparam bit DOWN_EN = 1'b0;
`endif

   logic         Clock = 1'b0;
   logic         Reset = 1'b0;
   logic         Enable = 1'b0;
   logic         Clear = 1'b0;
   logic         Load = 1'b0;
   logic [W-1:0] LoadValue = '0;
   logic         Dir = 1'b0;
   logic [W-1:0] Count;
   logic         TerminalCount;
   logic         CarryOut;
   logic         LoadErr;

   logic         c_en = 1'b0;
   logic [3:0]   lo_count, hi_count;
   logic         lo_tc, lo_co, lo_err, hi_tc, hi_co, hi_err;

   int n_cmp = 0;
   int n_bad = 0;
   int m_count = 0;
   bit m_err = 1'b0;

   always #5 Clock = ~Clock;

   mod_n_counter #(.MODULUS(MOD), .WIDTH(W)) dut (
      .Clock(Clock), .Reset(Reset), .Enable(Enable), .Clear(Clear), .Load(Load),
      .LoadValue(LoadValue), .Dir(Dir), .Count(Count),
      .TerminalCount(TerminalCount), .CarryOut(CarryOut), .LoadErr(LoadErr)
   );

   mod_n_counter #(.MODULUS(10), .WIDTH(4)) u_lo (
      .Clock(Clock), .Reset(Reset), .Enable(c_en), .Clear(1'b0), .Load(1'b0),
      .LoadValue(4'd0), .Dir(1'b0), .Count(lo_count),
      .TerminalCount(lo_tc), .CarryOut(lo_co), .LoadErr(lo_err)
   );

   mod_n_counter #(.MODULUS(10), .WIDTH(4)) u_hi (
      .Clock(Clock), .Reset(Reset), .Enable(lo_co), .Clear(1'b0), .Load(1'b0),
      .LoadValue(4'd0), .Dir(1'b0), .Count(hi_count),
      .TerminalCount(hi_tc), .CarryOut(hi_co), .LoadErr(hi_err)
   );

   // Reference model: the counter's rules expressed as integer arithmetic.
   function automatic void model_edge();
      bit down;
      down = DOWN_EN && Dir;
      m_err = 1'b0;
      if (Clear)                   m_count = 0;
      else if (Load && LoadValue < MOD) m_count = int'(LoadValue);
      else if (Load)               m_err = 1'b1;
      else if (Enable)             m_count = down ? (m_count + MOD - 1) % MOD
                                                  : (m_count + 1) % MOD;
   endfunction

   function automatic bit exp_tc();
      return m_count == ((DOWN_EN && Dir) ? 0 : MOD - 1);
   endfunction

   task automatic tick();
      @(posedge Clock);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      Enable = 1'b0; Clear = 1'b0; Load = 1'b0; c_en = 1'b0;
      Reset = 1'b1;
      #2;
      Reset = 1'b0;
      m_count = 0;
      m_err = 1'b0;
   endtask

   task automatic test_reset();
      Dir = 1'b0;
      Reset = 1'b1;
      #2;
      n_cmp++; if (Count !== '0) begin n_bad++; $display("FAIL reset_count: got %0d, required 0", Count); end
      n_cmp++; if (LoadErr !== 1'b0) begin n_bad++; $display("FAIL reset_loaderr: got %0b, required 0", LoadErr); end
      n_cmp++; if (TerminalCount !== 1'b0) begin n_bad++; $display("FAIL reset_tc_up: got %0b, required 0", TerminalCount); end
      Dir = 1'b1;
      #1;
      n_cmp++; if (TerminalCount !== DOWN_EN) begin n_bad++; $display("FAIL reset_tc_dir1: got %0b, required %0b", TerminalCount, DOWN_EN); end
      Dir = 1'b0;
      Reset = 1'b0;
      m_count = 0;
      m_err = 1'b0;
   endtask

   task automatic test_up_wrap();
      int seq [12] = '{0, 1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1};
      do_reset();
      Dir = 1'b0;
      Enable = 1'b1;
      #1;
      for (int i = 0; i < 12; i++) begin
         n_cmp++; if (Count !== W'(seq[i])) begin n_bad++; $display("FAIL up_wrap_count[%0d]: got %0d, required %0d", i, Count, seq[i]); end
         n_cmp++; if (CarryOut !== (seq[i] == 4)) begin n_bad++; $display("FAIL up_wrap_carry[%0d]: got %0b, required %0b", i, CarryOut, seq[i] == 4); end
         tick();
      end
      Enable = 1'b0;
   endtask

   task automatic test_load_err();
      Load = 1'b1; LoadValue = 3'd3;
      tick();
      n_cmp++; if (Count !== 3'd3) begin n_bad++; $display("FAIL load3_count: got %0d, required 3", Count); end
      n_cmp++; if (LoadErr !== 1'b0) begin n_bad++; $display("FAIL load3_err: got %0b, required 0", LoadErr); end
      LoadValue = 3'd6; Enable = 1'b1;
      tick();
      n_cmp++; if (Count !== 3'd3) begin n_bad++; $display("FAIL load6_count: got %0d, required 3", Count); end
      n_cmp++; if (LoadErr !== 1'b1) begin n_bad++; $display("FAIL load6_err: got %0b, required 1", LoadErr); end
      Load = 1'b0; Enable = 1'b0;
      tick();
      n_cmp++; if (LoadErr !== 1'b0) begin n_bad++; $display("FAIL load_err_pulse: got %0b, required 0", LoadErr); end
      n_cmp++; if (Count !== 3'd3) begin n_bad++; $display("FAIL load_hold_count: got %0d, required 3", Count); end
   endtask

   task automatic test_priority();
      Load = 1'b1; LoadValue = 3'd3;
      tick();
      Clear = 1'b1; Load = 1'b1; LoadValue = 3'd2; Enable = 1'b1;
      tick();
      n_cmp++; if (Count !== 3'd0) begin n_bad++; $display("FAIL prio_count: got %0d, required 0", Count); end
      n_cmp++; if (LoadErr !== 1'b0) begin n_bad++; $display("FAIL prio_err: got %0b, required 0", LoadErr); end
      LoadValue = 3'd7;
      tick();
      n_cmp++; if (LoadErr !== 1'b0) begin n_bad++; $display("FAIL clear_vs_bad_load_err: got %0b, required 0", LoadErr); end
      Clear = 1'b0; Load = 1'b0; Enable = 1'b0;
   endtask

   task automatic test_async_reset();
      do_reset();
      Dir = 1'b0;
      Enable = 1'b1;
      tick();
      tick();
      n_cmp++; if (Count !== 3'd2) begin n_bad++; $display("FAIL arst_pre_count: got %0d, required 2", Count); end
      @(negedge Clock);
      Reset = 1'b1;
      #1;
      n_cmp++; if (Count !== 3'd0) begin n_bad++; $display("FAIL arst_count: got %0d, required 0", Count); end
      #1;
      Reset = 1'b0;
      m_count = 0;
      m_err = 1'b0;
      tick();
      n_cmp++; if (Count !== 3'd1) begin n_bad++; $display("FAIL arst_resume: got %0d, required 1", Count); end
      Enable = 1'b0;
   endtask

   task automatic test_down();
      int dn [6] = '{4, 3, 2, 1, 0, 4};
      int up [6] = '{1, 2, 3, 4, 0, 1};
      int e;
      do_reset();
      Dir = 1'b1;
      #1;
      n_cmp++; if (TerminalCount !== DOWN_EN) begin n_bad++; $display("FAIL down_tc_at0: got %0b, required %0b", TerminalCount, DOWN_EN); end
      Enable = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         e = DOWN_EN ? dn[i] : up[i];
         n_cmp++; if (Count !== W'(e)) begin n_bad++; $display("FAIL down_count[%0d]: got %0d, required %0d", i, Count, e); end
         n_cmp++; if (TerminalCount !== (DOWN_EN ? (e == 0) : (e == 4))) begin
            n_bad++; $display("FAIL down_tc[%0d]: got %0b, required %0b", i, TerminalCount, DOWN_EN ? (e == 0) : (e == 4));
         end
      end
      Enable = 1'b0;
      Dir = 1'b0;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         Enable    = ($urandom_range(0, 3) != 0);
         Clear     = ($urandom_range(0, 15) == 0);
         Load      = ($urandom_range(0, 6) == 0);
         LoadValue = W'($urandom_range(0, 7));
         Dir       = $urandom_range(0, 1) == 1;
         tick();
         n_cmp++; if (Count !== W'(m_count)) begin n_bad++; $display("FAIL rand_count[%0d]: got %0d, required %0d", i, Count, m_count); end
         n_cmp++; if (LoadErr !== m_err) begin n_bad++; $display("FAIL rand_err[%0d]: got %0b, required %0b", i, LoadErr, m_err); end
         n_cmp++; if (TerminalCount !== exp_tc()) begin n_bad++; $display("FAIL rand_tc[%0d]: got %0b, required %0b", i, TerminalCount, exp_tc()); end
         n_cmp++; if (CarryOut !== (Enable && exp_tc())) begin n_bad++; $display("FAIL rand_carry[%0d]: got %0b, required %0b", i, CarryOut, Enable && exp_tc()); end
      end
      Enable = 1'b0; Clear = 1'b0; Load = 1'b0; Dir = 1'b0;
   endtask

   task automatic test_cascade();
      do_reset();
      c_en = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         @(posedge Clock);
         #1;
         n_cmp++; if (lo_count !== 4'(k % 10)) begin n_bad++; $display("FAIL cascade_lo[%0d]: got %0d, required %0d", k, lo_count, k % 10); end
         n_cmp++; if (hi_count !== 4'(k / 10)) begin n_bad++; $display("FAIL cascade_hi[%0d]: got %0d, required %0d", k, hi_count, k / 10); end
      end
      c_en = 1'b0;
      n_cmp++; if ({hi_count, lo_count} !== {4'd2, 4'd5}) begin
         n_bad++; $display("FAIL cascade_final: got {%0d,%0d}, required {2,5}", hi_count, lo_count);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      @(posedge Clock);
      #1;
      test_reset();
      test_up_wrap();
      test_load_err();
      test_priority();
      test_async_reset();
      test_down();
      test_random();
      test_cascade();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_mod_n_counter
